// File: rtl/drone_pkg.sv
// Shared types and constants for the RC link monitor.
package drone_pkg;

  localparam int unsigned PULSE_W    = 12;
  localparam int unsigned ARM_MAX_US = 1100;

  typedef enum logic [1:0] {
    SYNC_LOW,
    WAIT_RISE,
    MEASURE
  } rc_state_t;

  typedef struct packed {
    logic               valid;
    logic [PULSE_W-1:0] width_us;
  } rc_frame_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PULSE_W-1:0] sat_inc(input logic [PULSE_W-1:0] v,
                                                 input logic en);
    logic [PULSE_W-1:0] r;
    r = v;
    if (en && (v != '1)) r = v + PULSE_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/rc_link_monitor_if.sv
// RC receiver channel in, link status and pulse width out.
interface rc_link_monitor_if;
  import drone_pkg::*;

  logic               rc_pwm;
  logic               reciverenable;
  logic [PULSE_W-1:0] pulse_us;
  logic               frame_valid;
  logic               link_lost;

  modport master (
    input  rc_pwm,
    output reciverenable,
    output pulse_us,
    output frame_valid,
    output link_lost
  );

  modport slave (
    output rc_pwm,
    input  reciverenable,
    input  pulse_us,
    input  frame_valid,
    input  link_lost
  );
endinterface

// File: rtl/rc_pwm_sync.sv
// Two-flop synchronizer plus edge detect for the raw PWM input.
module rc_pwm_sync (
  input  logic clk,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Left unreset so a level already high during reset is still seen as high afterwards.
  always_ff @(posedge clk) begin
    meta <= din;
    sync <= meta;
    prev <= sync;
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/rc_link_monitor.sv
// Measures one RC PWM channel, range-checks each pulse and derives link lock / loss.
// Optional build macro RC_ARM_THROTTLE_EN: only low-throttle frames count toward lock.
module rc_link_monitor
  import drone_pkg::*;
#(
  parameter int unsigned CLK_PER_US   = 50,
  parameter int unsigned MIN_PULSE_US = 900,
  parameter int unsigned MAX_PULSE_US = 2100,
  parameter int unsigned TIMEOUT_US   = 50000,
  parameter int unsigned LOCK_FRAMES  = 4
) (
  input  logic           clk,
  input  logic           reset,
  rc_link_monitor_if.master link
);

  localparam int unsigned PRE_W  = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_US + 1);
  localparam int unsigned GOOD_W = $clog2(LOCK_FRAMES + 1);

  logic               level;
  logic               rise;
  logic               fall;
  logic [PRE_W-1:0]   prescaler;
  logic               us_tick_c;
  rc_state_t          state;
  rc_state_t          state_nxt;
  logic               width_clr_c;
  logic               width_run_c;
  logic               eval_c;
  logic [PULSE_W-1:0] width_cnt;
  logic [PULSE_W-1:0] width_meas_c;
  rc_frame_t          frame_c;
  logic [GOOD_W-1:0]  good_cnt;
  logic [GOOD_W-1:0]  good_sat_c;
  logic [GOOD_W-1:0]  good_nxt_c;
  logic [TO_W-1:0]    timeout_cnt;
  logic               timeout_hit_c;
  logic               reciverenable_q;
  logic [PULSE_W-1:0] pulse_us_q;
  logic               frame_valid_q;
  logic               link_lost_q;

  rc_pwm_sync u_sync (
    .clk   (clk),
    .din   (link.rc_pwm),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // Microsecond tick, phase counted from reset release.
  assign us_tick_c = (prescaler == PRE_W'(CLK_PER_US - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
    end else if (us_tick_c) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SYNC_LOW;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC_LOW:  if (!level) state_nxt = WAIT_RISE;
      WAIT_RISE: if (rise)   state_nxt = MEASURE;
      MEASURE:   if (fall)   state_nxt = WAIT_RISE;
      default:               state_nxt = SYNC_LOW;
    endcase
  end

  always_comb begin
    width_clr_c = 1'b0;
    width_run_c = 1'b0;
    eval_c      = 1'b0;
    case (state)
      WAIT_RISE: width_clr_c = rise;
      MEASURE: begin
        width_run_c = 1'b1;
        eval_c      = fall;
      end
      default: ;
    endcase
  end

  // Ticks are counted from the cycle after rise through the fall cycle itself.
  assign width_meas_c = sat_inc(width_cnt, us_tick_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      width_cnt <= '0;
    end else if (width_clr_c) begin
      width_cnt <= '0;
    end else if (width_run_c) begin
      width_cnt <= width_meas_c;
    end
  end

  always_comb begin
    frame_c.width_us = width_meas_c;
    frame_c.valid    = (width_meas_c >= PULSE_W'(MIN_PULSE_US)) &&
                       (width_meas_c <= PULSE_W'(MAX_PULSE_US));
  end

  // Next lock count for an accepted frame.
  always_comb begin
    good_sat_c = (good_cnt >= GOOD_W'(LOCK_FRAMES)) ? GOOD_W'(LOCK_FRAMES)
                                                     : good_cnt + GOOD_W'(1);
`ifdef RC_ARM_THROTTLE_EN
    good_nxt_c = (!reciverenable_q && (frame_c.width_us > PULSE_W'(ARM_MAX_US)))
                 ? '0 : good_sat_c;
`else
    good_nxt_c = good_sat_c;
`endif
  end

  assign timeout_hit_c = us_tick_c && (timeout_cnt == TO_W'(TIMEOUT_US - 1));

  // Frame evaluation and link supervision; an accepted frame overrides a coincident timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      reciverenable_q <= 1'b0;
      pulse_us_q      <= '0;
      frame_valid_q   <= 1'b0;
      link_lost_q     <= 1'b0;
      good_cnt        <= '0;
      timeout_cnt     <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      if (eval_c && frame_c.valid) begin
        frame_valid_q   <= 1'b1;
        pulse_us_q      <= frame_c.width_us;
        timeout_cnt     <= '0;
        link_lost_q     <= 1'b0;
        good_cnt        <= good_nxt_c;
        reciverenable_q <= (good_nxt_c == GOOD_W'(LOCK_FRAMES));
      end else begin
        if (us_tick_c && (timeout_cnt != TO_W'(TIMEOUT_US))) begin
          timeout_cnt <= timeout_cnt + TO_W'(1);
        end
        if (timeout_hit_c) begin
          link_lost_q     <= 1'b1;
          reciverenable_q <= 1'b0;
          good_cnt        <= '0;
        end
        if (eval_c) begin
          good_cnt        <= '0;
          reciverenable_q <= 1'b0;
        end
      end
    end
  end

  assign link.reciverenable = reciverenable_q;
  assign link.pulse_us      = pulse_us_q;
  assign link.frame_valid   = frame_valid_q;
  assign link.link_lost     = link_lost_q;

endmodule
